// File: rtl/trng_ctrl_pkg.sv
// Shared types and default parameters for the ring-oscillator TRNG controller.
package trng_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    COLLECT,
    FULL,
    ERROR
  } state_e;

  localparam int DEF_WORD_WIDTH    = 32;
  localparam int DEF_WARMUP_CYCLES = 256;
  localparam int DEF_REP_LIMIT     = 32;
  localparam bit DEF_DEBIAS        = 1'b1;

endpackage

// File: rtl/trng_ctrl_if.sv
// Word delivery channel from the TRNG controller to the bus wrapper.
// A word moves on a cycle where valid && ready.
interface trng_ctrl_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/trng_vn_debias.sv
// Von Neumann pair filter: emits the first bit of each unequal pair in the
// same cycle as the second bit arrives; with DEBIAS=0 every sample passes straight through.
module trng_vn_debias #(
  parameter bit DEBIAS = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic sample_en,
  input  logic bit_in,
  output logic bit_out,
  output logic bit_valid
);

  generate
    if (DEBIAS) begin : g_vn
      logic phase_q;
      logic first_q;

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          phase_q <= 1'b0;
          first_q <= 1'b0;
        end else if (sample_en) begin
          phase_q <= ~phase_q;
          if (!phase_q) first_q <= bit_in;
        end
      end

      assign bit_out   = first_q;
      assign bit_valid = sample_en && phase_q && (first_q != bit_in);
    end else begin : g_pass
      assign bit_out   = bit_in;
      assign bit_valid = sample_en;
    end
  endgenerate

endmodule

// File: rtl/trng_ctrl.sv
// TRNG sequencer: warm-up, (debiased) bit collection, repetition-count health test.
// A finished word is held on the output channel until accepted; collection stalls meanwhile.
module trng_ctrl
  import trng_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int REP_LIMIT     = DEF_REP_LIMIT,
  parameter bit DEBIAS        = DEF_DEBIAS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          trng_out,
  output logic          trng_en,
  output logic          error,
  trng_ctrl_if.master   out_if
);

  localparam int WCW = $clog2(WARMUP_CYCLES + 1);
  localparam int BCW = $clog2(WORD_WIDTH + 1);
  localparam int RCW = $clog2(REP_LIMIT + 1);

  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYCLES - 1);
  localparam logic [WCW-1:0] WARM_ONE  = WCW'(1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_WIDTH - 1);
  localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
  localparam logic [RCW-1:0] REP_TRIP  = RCW'(REP_LIMIT);
  localparam logic [RCW-1:0] REP_ONE   = RCW'(1);

  state_e                state_q;
  logic [WCW-1:0]        warm_cnt_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic [RCW-1:0]        rep_cnt_q, rep_cnt_d;
  logic                  prev_q;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  trng_en_q, valid_q, error_q;
  logic                  rep_trip, word_done;
  logic                  vn_bit, vn_vld;
  logic                  collecting;

  assign collecting = (state_q == COLLECT);

  trng_vn_debias #(.DEBIAS(DEBIAS)) u_debias (
    .clk       (clk),
    .reset     (reset),
    .clear     (!collecting),
    .sample_en (collecting),
    .bit_in    (trng_out),
    .bit_out   (vn_bit),
    .bit_valid (vn_vld)
  );

  // Repetition count on raw samples; a zero count marks the first sample of a run.
  always_comb begin
    rep_cnt_d = REP_ONE;
    if (rep_cnt_q != '0 && trng_out == prev_q) rep_cnt_d = rep_cnt_q + REP_ONE;
    rep_trip  = (rep_cnt_d == REP_TRIP);
    word_done = vn_vld && (bit_cnt_q == BIT_LAST);
    data_d    = {data_q[WORD_WIDTH-2:0], vn_bit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      warm_cnt_q <= '0;
      bit_cnt_q  <= '0;
      rep_cnt_q  <= '0;
      prev_q     <= 1'b0;
      data_q     <= '0;
      trng_en_q  <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else if (!enable) begin
      state_q    <= IDLE;
      warm_cnt_q <= '0;
      bit_cnt_q  <= '0;
      rep_cnt_q  <= '0;
      trng_en_q  <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= WARMUP;
          warm_cnt_q <= '0;
          trng_en_q  <= 1'b1;
        end
        WARMUP: begin
          if (warm_cnt_q == WARM_LAST) begin
            state_q   <= COLLECT;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            data_q    <= '0;
          end else begin
            warm_cnt_q <= warm_cnt_q + WARM_ONE;
          end
        end
        COLLECT: begin
          rep_cnt_q <= rep_cnt_d;
          prev_q    <= trng_out;
          // A health failure wins over a word completing on the same sample.
          if (rep_trip) begin
            state_q   <= ERROR;
            error_q   <= 1'b1;
            trng_en_q <= 1'b0;
          end else if (vn_vld) begin
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_q + BIT_ONE;
            if (word_done) begin
              state_q <= FULL;
              valid_q <= 1'b1;
            end
          end
        end
        FULL: begin
          if (out_if.ready) begin
            state_q   <= COLLECT;
            valid_q   <= 1'b0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            data_q    <= '0;
          end
        end
        ERROR: begin
          state_q <= ERROR;
        end
        default: begin
          state_q   <= IDLE;
          trng_en_q <= 1'b0;
          valid_q   <= 1'b0;
          error_q   <= 1'b0;
        end
      endcase
    end
  end

  assign trng_en      = trng_en_q;
  assign error        = error_q;
  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed bench for trng_ctrl: stimulus pushes expected words, a monitor pops on each handshake.
module tb_trng_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic trng_out;
  logic trng_en;
  logic error;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

  trng_ctrl_if #(.WORD_WIDTH(32)) bus ();

  trng_ctrl #(
    .WORD_WIDTH    (32),
    .WARMUP_CYCLES (4),
    .REP_LIMIT     (8),
    .DEBIAS        (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .trng_out (trng_out),
    .trng_en  (trng_en),
    .error    (error),
    .out_if   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one raw sample for the next posedge and return just after it.
  task automatic step(input logic b);
    trng_out = b;
    @(posedge clk);
    #1;
  endtask

  // Each word bit b becomes the pair (b, ~b), so the debiased stream is exactly w.
  task automatic send_word(input logic [31:0] w);
    sb.push_back(w);
    for (int i = 31; i >= 0; i--) begin
      step(w[i]);
      if (i == 0) chk("valid_before_last_sample", {31'b0, bus.valid}, 32'd0);
      step(~w[i]);
    end
    chk("valid_after_64_samples", {31'b0, bus.valid}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.valid && bus.ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %h expected none", bus.data);
      end else begin
        chk("word_data", bus.data, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] pat;
    reset     = 1'b1;
    enable    = 1'b1;
    trng_out  = 1'b0;
    bus.ready = 1'b1;

    // Reset held with enable asserted
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trng_en", {31'b0, trng_en}, 32'd0);
    chk("rst_valid",   {31'b0, bus.valid}, 32'd0);
    chk("rst_error",   {31'b0, error}, 32'd0);
    chk("rst_data",    bus.data, 32'd0);
    reset = 1'b0;
    step(1'b0);
    chk("trng_en_after_release", {31'b0, trng_en}, 32'd1);

    // Warm-up samples that would corrupt the word if taken
    step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    send_word(32'hFFFF_FFFF);
    step(1'b1);
    chk("valid_drop_after_hs", {31'b0, bus.valid}, 32'd0);
    send_word(32'h0000_0000);
    step(1'b1);
    chk("valid_drop_after_hs2", {31'b0, bus.valid}, 32'd0);

    // Equal pairs interleaved with unequal ones
    pat = 8'b0010_1101;
    sb.push_back(32'hAAAA_AAAA);
    for (int k = 0; k < 128; k++) begin
      if (k == 127) chk("mixed_valid_before_last", {31'b0, bus.valid}, 32'd0);
      step(pat[7 - (k % 8)]);
    end
    chk("mixed_valid_after_128", {31'b0, bus.valid}, 32'd1);
    step(1'b1);
    chk("valid_drop_after_hs3", {31'b0, bus.valid}, 32'd0);

    // Consumer stall
    bus.ready = 1'b0;
    send_word(32'h1234_5678);
    for (int k = 0; k < 10; k++) begin
      step(1'b0);
      chk("stall_valid", {31'b0, bus.valid}, 32'd1);
      chk("stall_data", bus.data, 32'h1234_5678);
    end
    bus.ready = 1'b1;
    step(1'b0);
    chk("valid_drop_after_stall", {31'b0, bus.valid}, 32'd0);
    send_word(32'hCAFE_F00D);
    step(1'b1);
    chk("valid_drop_after_hs4", {31'b0, bus.valid}, 32'd0);

    // Stuck-at-1 source trips the repetition test on the 8th sample
    for (int k = 0; k < 7; k++) step(1'b1);
    chk("error_before_8th", {31'b0, error}, 32'd0);
    step(1'b1);
    chk("error_after_8th", {31'b0, error}, 32'd1);
    chk("trng_en_in_error", {31'b0, trng_en}, 32'd0);
    chk("valid_in_error", {31'b0, bus.valid}, 32'd0);
    step(1'b1); step(1'b1); step(1'b1);
    chk("error_sticky", {31'b0, error}, 32'd1);
    enable = 1'b0;
    step(1'b0);
    chk("error_cleared", {31'b0, error}, 32'd0);
    chk("trng_en_idle", {31'b0, trng_en}, 32'd0);

    // Partial word abandoned by enable=0, then a fresh warm-up
    enable = 1'b1;
    step(1'b0);
    chk("trng_en_reenable", {31'b0, trng_en}, 32'd1);
    step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    for (int k = 0; k < 10; k++) begin
      step(1'b1);
      step(1'b0);
    end
    enable = 1'b0;
    step(1'b0);
    chk("trng_en_drop_partial", {31'b0, trng_en}, 32'd0);
    chk("valid_drop_partial", {31'b0, bus.valid}, 32'd0);
    enable = 1'b1;
    step(1'b0);
    chk("trng_en_rewarm", {31'b0, trng_en}, 32'd1);
    step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    send_word(32'h0F0F_5A5A);
    step(1'b0);
    step(1'b0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
